axis_to_aximm_writer: RTL and testbench

- Write-only AXI4 master that drains a 512-bit AXI-Stream of captured packet data into memory as fixed-size INCR bursts.
- Sits directly upstream of the sliding-window address stage. Its M_AXI write channels connect to that stage's S_AXI write channels.
- Addresses it emits are pre-window; the window stage adds window_addr for addresses at or above WINDOW_START.
- The integrator ties off the read channels at the top level.

---
 rtl/axis_to_aximm_writer.sv | 213 +++++++++++++++++++++
 tb/tb_axis_to_aximm_writer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_to_aximm_writer.sv
`default_nettype none
// ============================================================================
// Module  : axis_to_aximm_writer
// Brief   : Drains a DW-bit AXI-Stream into memory as fixed-size AXI4 INCR
//           write bursts, keeping up to MAX_OUTSTANDING bursts in flight.
// Rev     : 1.0  initial release
// ============================================================================
module axis_to_aximm_writer #(
    parameter int DW              = 512,
    parameter int AW              = 64,
    parameter int BURST_BEATS     = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [31:0]     num_beats,
    output logic            busy,
    output logic            done,
    output logic            error,

    input  logic [DW-1:0]   AXIS_RX_TDATA,
    input  logic            AXIS_RX_TVALID,
    output logic            AXIS_RX_TREADY,

    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic [3:0]      M_AXI_AWID,
    output logic            M_AXI_AWLOCK,
    output logic [3:0]      M_AXI_AWCACHE,
    output logic [3:0]      M_AXI_AWQOS,
    output logic [2:0]      M_AXI_AWPROT,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,

    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WVALID,
    output logic            M_AXI_WLAST,
    input  logic            M_AXI_WREADY,

    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY
);

    localparam int            BEAT_BYTES  = DW / 8;
    localparam int            BEAT_SHIFT  = $clog2(BEAT_BYTES);
    localparam int            BURST_BYTES = BURST_BEATS * BEAT_BYTES;
    localparam int            LEN_W       = $clog2(BURST_BEATS) + 1;
    localparam logic [AW-1:0] ALIGN_MASK  = ~(AW'(BURST_BYTES) - AW'(1));
    localparam logic [3:0]    MAX_OUT     = 4'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND_AW = 2'd1,
        S_SEND_W  = 2'd2,
        S_DRAIN_B = 2'd3
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_awaddr;
    logic [LEN_W-1:0] r_burst_len;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [31:0]      r_beats_left;
    logic [3:0]       r_outstanding;
    logic             r_awvalid;
    logic             r_bready;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic             w_in_w;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_b_hs;
    logic             w_last_beat;
    logic [LEN_W-1:0] w_awlen;
    logic [3:0]       w_out_next;
    logic [31:0]      w_left_after;
    logic [AW-1:0]    w_base_aligned;

    function automatic logic [LEN_W-1:0] clip_len(input logic [31:0] beats);
        if (beats >= 32'(BURST_BEATS)) begin
            return LEN_W'(BURST_BEATS);
        end
        return beats[LEN_W-1:0];
    endfunction

    assign w_in_w         = (r_state == S_SEND_W);
    assign w_aw_hs        = r_awvalid && M_AXI_AWREADY;
    assign w_w_hs         = w_in_w && AXIS_RX_TVALID && M_AXI_WREADY;
    assign w_b_hs         = M_AXI_BVALID && r_bready;
    assign w_awlen        = r_burst_len - LEN_W'(1);
    assign w_last_beat    = (r_beat_cnt == w_awlen);
    assign w_out_next     = r_outstanding + {3'd0, w_aw_hs} - {3'd0, w_b_hs};
    assign w_left_after   = r_beats_left - 32'(r_burst_len);
    assign w_base_aligned = base_addr & ALIGN_MASK;

    // The W channel is a straight wire to the stream while a burst is open.
    assign AXIS_RX_TREADY = w_in_w && M_AXI_WREADY;
    assign M_AXI_WVALID   = w_in_w && AXIS_RX_TVALID;
    assign M_AXI_WDATA    = AXIS_RX_TDATA;
    assign M_AXI_WLAST    = w_in_w && w_last_beat;
    assign M_AXI_WSTRB    = '1;

    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWLEN   = 8'(w_awlen);
    assign M_AXI_AWSIZE  = 3'(BEAT_SHIFT);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWID    = 4'd0;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_AWQOS   = 4'd0;
    assign M_AXI_AWPROT  = 3'd0;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_BREADY  = r_bready;

    assign busy  = r_busy;
    assign done  = r_done;
    assign error = r_error;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_awaddr      <= '0;
            r_burst_len   <= '0;
            r_beat_cnt    <= '0;
            r_beats_left  <= '0;
            r_outstanding <= '0;
            r_awvalid     <= 1'b0;
            r_bready      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_bready      <= 1'b1;
            r_done        <= 1'b0;
            r_outstanding <= w_out_next;
            if (w_b_hs && (M_AXI_BRESP != 2'b00)) begin
                r_error <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_awaddr     <= w_base_aligned;
                        r_beats_left <= num_beats;
                        r_burst_len  <= clip_len(num_beats);
                        r_beat_cnt   <= '0;
                        r_error      <= 1'b0;
                        if (num_beats == 32'd0) begin
                            // Nothing can be in flight here, so the drain is
                            // already complete: finish in the very next cycle.
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_busy    <= 1'b1;
                            r_awvalid <= (w_out_next < MAX_OUT);
                            r_state   <= S_SEND_AW;
                        end
                    end
                end

                S_SEND_AW: begin
                    if (r_awvalid) begin
                        if (M_AXI_AWREADY) begin
                            r_awvalid <= 1'b0;
                            r_awaddr  <= r_awaddr + (AW'(r_burst_len) << BEAT_SHIFT);
                            r_state   <= S_SEND_W;
                        end
                    end else if (w_out_next < MAX_OUT) begin
                        r_awvalid <= 1'b1;
                    end
                end

                S_SEND_W: begin
                    if (w_w_hs) begin
                        if (w_last_beat) begin
                            r_beat_cnt   <= '0;
                            r_beats_left <= w_left_after;
                            if (w_left_after != 32'd0) begin
                                r_burst_len <= clip_len(w_left_after);
                                r_awvalid   <= (w_out_next < MAX_OUT);
                                r_state     <= S_SEND_AW;
                            end else begin
                                r_state <= S_DRAIN_B;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + LEN_W'(1);
                        end
                    end
                end

                S_DRAIN_B: begin
                    if (r_outstanding == 4'd0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_to_aximm_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_axis_to_aximm_writer
// Brief   : Self-checking bench: random stream/slave timing against a
//           burst-list and beat-queue reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_axis_to_aximm_writer;

    localparam int     DW          = 512;
    localparam int     AW          = 64;
    localparam int     BB          = 64;
    localparam int     MAXO        = 4;
    localparam longint BURST_BYTES = BB * (DW / 8);

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic [31:0]     num_beats;
    logic            busy, done, error;
    logic [DW-1:0]   AXIS_RX_TDATA;
    logic            AXIS_RX_TVALID, AXIS_RX_TREADY;
    logic [AW-1:0]   M_AXI_AWADDR;
    logic [7:0]      M_AXI_AWLEN;
    logic [2:0]      M_AXI_AWSIZE;
    logic [1:0]      M_AXI_AWBURST;
    logic [3:0]      M_AXI_AWID;
    logic            M_AXI_AWLOCK;
    logic [3:0]      M_AXI_AWCACHE;
    logic [3:0]      M_AXI_AWQOS;
    logic [2:0]      M_AXI_AWPROT;
    logic            M_AXI_AWVALID, M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WVALID, M_AXI_WLAST, M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP;
    logic            M_AXI_BVALID, M_AXI_BREADY;

    always #5 clk = ~clk;

    axis_to_aximm_writer #(
        .DW(DW), .AW(AW), .BURST_BEATS(BB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .start(start), .base_addr(base_addr), .num_beats(num_beats),
        .busy(busy), .done(done), .error(error),
        .AXIS_RX_TDATA(AXIS_RX_TDATA), .AXIS_RX_TVALID(AXIS_RX_TVALID),
        .AXIS_RX_TREADY(AXIS_RX_TREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY)
    );

    typedef struct {
        logic [AW-1:0] base;
        int            num;
        int            tv, wr, awr, bv;
        int            err_b;
        int            bursts;
        logic          err_exp;
    } vec_t;

    vec_t vecs[7];

    int checks = 0;
    int failures = 0;

    // Reference model: expected bursts, expected beat order, open-burst lengths.
    logic [AW-1:0] exp_addr_q[$];
    int            exp_len_q[$];
    int            wl_q[$];
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_w_q[$];
    int w_in_burst = 0, aw_cnt = 0, b_cnt = 0, wdone_cnt = 0, done_cnt = 0, viol = 0;

    int tv_pct = 100, wr_pct = 100, awr_pct = 100, bv_pct = 100;
    int b_limit = 1 << 30;
    int err_idx = -1;

    logic s_awvalid, s_wvalid, s_tready, s_busy, s_done, s_error, s_bready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s beat_in_burst=%0d actual[63:0]=0x%h required[63:0]=0x%h",
                     name, w_in_burst, act[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    // One clock: observe at the falling edge, drive just after the rising edge.
    task automatic step();
        logic aw_hs, w_hs, b_hs, t_hs;
        @(negedge clk);
        s_awvalid = M_AXI_AWVALID;
        s_wvalid  = M_AXI_WVALID;
        s_tready  = AXIS_RX_TREADY;
        s_busy    = busy;
        s_done    = done;
        s_error   = error;
        s_bready  = M_AXI_BREADY;
        aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
        w_hs  = M_AXI_WVALID && M_AXI_WREADY;
        b_hs  = M_AXI_BVALID && M_AXI_BREADY;
        t_hs  = AXIS_RX_TVALID && AXIS_RX_TREADY;

        if (M_AXI_AWVALID && ((aw_cnt - b_cnt) >= MAXO || exp_addr_q.size() == 0)) viol++;
        if ((M_AXI_WVALID || AXIS_RX_TREADY) && wl_q.size() == 0) viol++;
        if (w_hs != t_hs) viol++;

        // W before AW so a beat in the AW handshake cycle is flagged.
        if (w_hs) begin
            if (exp_w_q.size() == 0 || wl_q.size() == 0) begin
                check("w_beat_expected", 1'b0, 1'b1);
            end else begin
                check_data("wdata", M_AXI_WDATA, exp_w_q[0]);
                exp_w_q.delete(0);
                w_in_burst++;
                check("wlast", M_AXI_WLAST, w_in_burst == wl_q[0]);
                if (w_in_burst == wl_q[0]) begin
                    wl_q.delete(0);
                    w_in_burst = 0;
                    wdone_cnt++;
                end
            end
        end
        if (aw_hs) begin
            if (exp_addr_q.size() == 0) begin
                check("aw_expected", 1'b0, 1'b1);
            end else begin
                check("awaddr", M_AXI_AWADDR, exp_addr_q[0]);
                check("awlen", M_AXI_AWLEN, exp_len_q[0] - 1);
                wl_q.push_back(exp_len_q[0]);
                exp_addr_q.delete(0);
                exp_len_q.delete(0);
            end
            aw_cnt++;
        end
        if (b_hs) b_cnt++;
        if (done) done_cnt++;

        @(posedge clk);
        #1;
        if (t_hs) src_q.delete(0);
        if (b_hs) M_AXI_BVALID = 1'b0;
        if (!M_AXI_BVALID && b_cnt < b_limit && wdone_cnt > b_cnt && pct(bv_pct)) begin
            M_AXI_BVALID = 1'b1;
            M_AXI_BRESP  = (b_cnt == err_idx) ? 2'b10 : 2'b00;
        end
        if (!(AXIS_RX_TVALID && !t_hs)) begin
            AXIS_RX_TVALID = (src_q.size() > 0) && pct(tv_pct);
            AXIS_RX_TDATA  = (src_q.size() > 0) ? src_q[0] : rand_dw();
        end
        M_AXI_AWREADY = pct(awr_pct);
        M_AXI_WREADY  = pct(wr_pct);
    endtask

    task automatic model_clear();
        exp_addr_q.delete(); exp_len_q.delete(); wl_q.delete();
        src_q.delete(); exp_w_q.delete();
        w_in_burst = 0; aw_cnt = 0; b_cnt = 0; wdone_cnt = 0; done_cnt = 0; viol = 0;
        AXIS_RX_TVALID = 1'b0;
        M_AXI_BVALID   = 1'b0;
        M_AXI_BRESP    = 2'b00;
    endtask

    task automatic begin_job(input logic [AW-1:0] base, input int num);
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int rem;
        model_clear();
        a   = base - (base % BURST_BYTES);
        rem = num;
        while (rem > 0) begin
            exp_addr_q.push_back(a);
            exp_len_q.push_back(rem > BB ? BB : rem);
            a   = a + BURST_BYTES;
            rem = rem - BB;
        end
        for (int i = 0; i < num; i++) begin
            d = rand_dw();
            src_q.push_back(d);
            exp_w_q.push_back(d);
        end
        base_addr = base;
        num_beats = num;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bursts, input logic err_exp);
        for (int c = 0; c < 20000 && done_cnt == 0; c++) step();
        check({tag, "_done_seen"}, done_cnt, 1);
        check({tag, "_busy_at_done"}, s_busy, 1'b0);
        check({tag, "_aw_count"}, aw_cnt, bursts);
        check({tag, "_b_count"}, b_cnt, bursts);
        check({tag, "_error_at_done"}, s_error, err_exp);
        repeat (3) step();
        check({tag, "_done_single"}, done_cnt, 1);
        check({tag, "_error_held"}, s_error, err_exp);
        check({tag, "_beats_unwritten"}, exp_w_q.size(), 0);
        check({tag, "_protocol"}, viol, 0);
    endtask

    task automatic run_job(input string tag, input logic [AW-1:0] base, input int num,
                           input int bursts, input logic err_exp);
        begin_job(base, num);
        step();
        check({tag, "_busy_after_start"}, s_busy, num != 0);
        check({tag, "_awvalid_after_start"}, s_awvalid, num != 0);
        check({tag, "_done_after_start"}, s_done, num == 0);
        check({tag, "_error_cleared"}, s_error, 1'b0);
        wait_done(tag, bursts, err_exp);
    endtask

    initial begin
        int nb;
        reset = 1'b1; start = 1'b0; base_addr = '0; num_beats = '0;
        AXIS_RX_TDATA = '0; AXIS_RX_TVALID = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;

        vecs[0] = '{64'h10_0000_0000, 150, 100, 100, 100, 100, -1, 3, 1'b0};
        vecs[1] = '{64'h10_0000_0000, 150,  50,  50,  50,  70, -1, 3, 1'b0};
        vecs[2] = '{64'h10_0000_0ABC,  64,  70,  60,  40,  50, -1, 1, 1'b0};
        vecs[3] = '{64'h0000_2000,     65,  60,  60,  60,  60, -1, 2, 1'b0};
        vecs[4] = '{64'h0000_5000,    150,  80,  80,  80,  80,  1, 3, 1'b1};
        vecs[5] = '{64'h0000_7040,      1, 100, 100, 100, 100, -1, 1, 1'b0};
        vecs[6] = '{64'h0000_9000,    128,  90,  40,  30,  50, -1, 2, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        step();
        check("rst_awvalid", s_awvalid, 1'b0);
        check("rst_wvalid", s_wvalid, 1'b0);
        check("rst_tready", s_tready, 1'b0);
        check("rst_bready", s_bready, 1'b0);
        check("rst_busy", s_busy, 1'b0);
        check("rst_done", s_done, 1'b0);
        check("rst_error", s_error, 1'b0);
        check("rst_wlast", M_AXI_WLAST, 1'b0);
        check("awsize", M_AXI_AWSIZE, 3'd6);
        check("awburst", M_AXI_AWBURST, 2'b01);
        check("awcache", M_AXI_AWCACHE, 4'b0011);
        check("awid_lock_qos_prot", {M_AXI_AWID, M_AXI_AWLOCK, M_AXI_AWQOS, M_AXI_AWPROT}, 0);
        check("wstrb_all_ones", &M_AXI_WSTRB, 1'b1);
        reset = 1'b0;
        step();
        step();
        check("bready_after_reset", s_bready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            tv_pct = vecs[i].tv; wr_pct = vecs[i].wr; awr_pct = vecs[i].awr; bv_pct = vecs[i].bv;
            err_idx = vecs[i].err_b; b_limit = 1 << 30;
            run_job($sformatf("vec%0d", i), vecs[i].base, vecs[i].num, vecs[i].bursts, vecs[i].err_exp);
        end

        tv_pct = 100; wr_pct = 100; awr_pct = 100; bv_pct = 100; err_idx = -1;
        run_job("zero_len", 64'h0000_3000, 0, 0, 1'b0);

        // Outstanding limit: all B responses withheld.
        b_limit = 0;
        begin_job(64'h20_0000_0000, 640);
        for (int c = 0; c < 600; c++) step();
        check("ol_aw_count_capped", aw_cnt, MAXO);
        check("ol_awvalid_low", s_awvalid, 1'b0);
        check("ol_no_early_done", done_cnt, 0);
        b_limit = 1;
        for (int c = 0; c < 30 && aw_cnt < MAXO + 1; c++) step();
        check("ol_fifth_aw", aw_cnt, MAXO + 1);
        check("ol_one_b", b_cnt, 1);
        b_limit = 1 << 30;
        wait_done("ol", 10, 1'b0);

        // Reset during beat 30 of the first burst.
        begin_job(64'h30_0000_0000, 200);
        for (int c = 0; c < 500 && !(aw_cnt == 1 && w_in_burst == 29); c++) step();
        check("mid_reset_reached_beat30", w_in_burst, 29);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        step();
        check("mid_reset_awvalid", s_awvalid, 1'b0);
        check("mid_reset_wvalid", s_wvalid, 1'b0);
        check("mid_reset_tready", s_tready, 1'b0);
        check("mid_reset_busy", s_busy, 1'b0);
        check("mid_reset_done", s_done, 1'b0);
        step();
        run_job("post_reset", 64'h40_0000_0100, 100, 2, 1'b0);

        for (int i = 0; i < 3; i++) begin
            tv_pct  = int'($urandom_range(30, 100));
            wr_pct  = int'($urandom_range(30, 100));
            awr_pct = int'($urandom_range(30, 100));
            bv_pct  = int'($urandom_range(30, 100));
            nb      = int'($urandom_range(1, 300));
            err_idx = int'($urandom_range(0, 6));
            run_job($sformatf("rand%0d", i), {$urandom, $urandom}, nb,
                    (nb + BB - 1) / BB, err_idx < (nb + BB - 1) / BB);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
